// File: rtl/jpeg_sched_pkg.sv
// Shared types and lookups for the JPEG MCU scheduler: FSM states, chroma modes,
// blocks-per-MCU and block-to-component mapping, and the tag width rule.
package jpeg_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HAND,
        ST_NEXT,
        ST_RSTW,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] MODE_GRAY = 2'd0;
    localparam logic [1:0] MODE_444  = 2'd1;
    localparam logic [1:0] MODE_422  = 2'd2;
    localparam logic [1:0] MODE_420  = 2'd3;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    // Tag = {last_in_mcu, blk_idx[3:0], comp[1:0], x, y}
    function automatic int tag_width(input int xy_w);
        return 7 + 2 * xy_w;
    endfunction

    function automatic logic [3:0] blocks_per_mcu(input logic [1:0] mode);
        case (mode)
            MODE_GRAY: return 4'd1;
            MODE_444:  return 4'd3;
            MODE_422:  return 4'd4;
            default:   return 4'd6;
        endcase
    endfunction

    // Luma blocks come first, then one Cb and one Cr block.
    function automatic logic [1:0] block_comp(input logic [1:0] mode, input logic [3:0] blk);
        logic [3:0] n_y;
        case (mode)
            MODE_422: n_y = 4'd2;
            MODE_420: n_y = 4'd4;
            default:  n_y = 4'd1;
        endcase
        if (blk < n_y)
            return COMP_Y;
        else if (blk == n_y)
            return COMP_CB;
        else
            return COMP_CR;
    endfunction

endpackage

// File: rtl/jpeg_tag_slot.sv
// One back-end slot: holds {valid, done, tag} and raises start in the first
// cycle the slot is valid.
module jpeg_tag_slot #(
    parameter int TAG_W = 33
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [TAG_W-1:0] load_tag,
    input  logic             done_in,
    input  logic             pop,
    output logic             valid,
    output logic             done,
    output logic             start,
    output logic [TAG_W-1:0] tag
);

    logic fresh;

    // load only happens into an invalid slot and pop only out of a valid one,
    // so the two never coincide.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= 1'b0;
            done  <= 1'b0;
            fresh <= 1'b0;
            tag   <= '0;
        end else begin
            fresh <= load;
            if (load) begin
                valid <= 1'b1;
                done  <= 1'b0;
                tag   <= load_tag;
            end else if (pop) begin
                valid <= 1'b0;
                done  <= 1'b0;
            end else if (valid && done_in) begin
                done <= 1'b1;
            end
        end
    end

    assign start = valid & fresh;

endmodule

// File: rtl/jpeg_mcu_sched.sv
// MCU scheduler: issues block decodes in MCU order, handles restart markers and
// carries each block's position tag through NUM_STAGES back-end slots.
module jpeg_mcu_sched #(
    parameter int NUM_STAGES = 4,
    parameter int XY_W       = 13,
    parameter int RI_W       = 16,
    localparam int TAG_W     = jpeg_sched_pkg::tag_width(XY_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [1:0]                  mode,
    input  logic [XY_W-1:0]             mcu_w,
    input  logic [XY_W-1:0]             mcu_h,
    input  logic [RI_W-1:0]             restart_interval,
    output logic                        dec_req,
    output logic [1:0]                  dec_comp,
    input  logic                        dec_done,
    output logic                        dc_pred_clr,
    output logic                        rst_expect,
    input  logic                        rst_seen,
    input  logic [2:0]                  rst_idx,
    output logic                        err_rst,
    output logic [NUM_STAGES-1:0]       stg_start,
    input  logic [NUM_STAGES-1:0]       stg_done,
    output logic [NUM_STAGES*TAG_W-1:0] stg_tag,
    output logic                        out_valid,
    output logic [TAG_W-1:0]            out_tag,
    input  logic                        out_ready,
    input  logic                        out_empty,
    output logic                        busy,
    output logic                        frame_done
);

    import jpeg_sched_pkg::*;

    localparam int LAST = NUM_STAGES - 1;
    localparam logic [XY_W-1:0] XY_ONE = 1;
    localparam logic [RI_W-1:0] RI_ONE = 1;

    state_t state, state_n;

    logic [1:0]      mode_q;
    logic [XY_W-1:0] w_q, h_q, x_q, y_q;
    logic [RI_W-1:0] ri_q, rst_cnt, rst_cnt_inc;
    logic [3:0]      blk, bpm_m1;
    logic [2:0]      exp_idx;
    logic            err_q, clr_q, fd_q;
    logic            flush, blk_last, x_last, y_last, ri_hit;
    logic [TAG_W-1:0] hand_tag;

    logic [NUM_STAGES-1:0] s_valid, s_done, s_load, s_pop;
    logic [TAG_W-1:0]      s_tag [NUM_STAGES];

    assign flush       = rst | abort;
    assign bpm_m1      = blocks_per_mcu(mode_q) - 4'd1;
    assign blk_last    = (blk == bpm_m1);
    assign x_last      = (x_q == w_q - XY_ONE);
    assign y_last      = (y_q == h_q - XY_ONE);
    assign rst_cnt_inc = rst_cnt + RI_ONE;
    assign ri_hit      = (ri_q != '0) && (rst_cnt_inc == ri_q);
    assign hand_tag    = {blk_last, blk, block_comp(mode_q, blk), x_q, y_q};

    always_ff @(posedge clk) begin
        if (flush)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_ISSUE;
            ST_ISSUE: if (dec_done) state_n = ST_HAND;
            ST_HAND:  if (!s_valid[0]) state_n = ST_NEXT;
            ST_NEXT: begin
                if (!blk_last)
                    state_n = ST_ISSUE;
                else if (x_last && y_last)
                    state_n = ST_DRAIN;
                else if (ri_hit)
                    state_n = ST_RSTW;
                else
                    state_n = ST_ISSUE;
            end
            ST_RSTW:  if (rst_seen) state_n = ST_ISSUE;
            ST_DRAIN: if ((s_valid == '0) && out_empty) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // err_rst survives abort; only rst or a new frame clears it.
    always_ff @(posedge clk) begin
        if (flush) begin
            mode_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            ri_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            blk     <= '0;
            rst_cnt <= '0;
            exp_idx <= '0;
            clr_q   <= 1'b0;
            fd_q    <= 1'b0;
            if (rst)
                err_q <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            fd_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        w_q     <= mcu_w;
                        h_q     <= mcu_h;
                        ri_q    <= restart_interval;
                        x_q     <= '0;
                        y_q     <= '0;
                        blk     <= '0;
                        rst_cnt <= '0;
                        exp_idx <= '0;
                        err_q   <= 1'b0;
                        clr_q   <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (!blk_last) begin
                        blk <= blk + 4'd1;
                    end else begin
                        blk     <= '0;
                        rst_cnt <= ri_hit ? '0 : rst_cnt_inc;
                        if (!(x_last && y_last)) begin
                            if (x_last) begin
                                x_q <= '0;
                                y_q <= y_q + XY_ONE;
                            end else begin
                                x_q <= x_q + XY_ONE;
                            end
                        end
                    end
                end
                ST_RSTW: begin
                    if (rst_seen) begin
                        if (rst_idx != exp_idx)
                            err_q <= 1'b1;
                        exp_idx <= exp_idx + 3'd1;
                        clr_q   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (state_n == ST_IDLE)
                        fd_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Slot k fills only from an invalid state, so a slot freed at one edge
    // refills no earlier than the next edge.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
        logic [TAG_W-1:0] src_tag;
        logic             slot_start;

        if (k == 0) begin : g_head
            assign s_load[k] = (state == ST_HAND) && !s_valid[0];
            assign src_tag   = hand_tag;
        end else begin : g_body
            assign s_load[k] = s_valid[k-1] && s_done[k-1] && !s_valid[k];
            assign src_tag   = s_tag[k-1];
        end

        if (k == LAST) begin : g_tail
            assign s_pop[k] = out_valid && out_ready;
        end else begin : g_mid
            assign s_pop[k] = s_load[k+1];
        end

        jpeg_tag_slot #(.TAG_W(TAG_W)) u_slot (
            .clk      (clk),
            .clr      (flush),
            .load     (s_load[k]),
            .load_tag (src_tag),
            .done_in  (stg_done[k]),
            .pop      (s_pop[k]),
            .valid    (s_valid[k]),
            .done     (s_done[k]),
            .start    (slot_start),
            .tag      (s_tag[k])
        );

        assign stg_start[k]              = slot_start;
        assign stg_tag[k*TAG_W +: TAG_W] = s_tag[k];
    end

    assign out_valid   = s_valid[LAST] & s_done[LAST];
    assign out_tag     = s_tag[LAST];
    assign dec_req     = (state == ST_ISSUE);
    assign dec_comp    = dec_req ? block_comp(mode_q, blk) : 2'd0;
    assign rst_expect  = (state == ST_RSTW);
    assign busy        = (state != ST_IDLE);
    assign dc_pred_clr = clr_q;
    assign frame_done  = fd_q;
    assign err_rst     = err_q;

endmodule

// File: tb/tb_jpeg_mcu_sched.sv
// Bench for jpeg_mcu_sched: directed frames plus randomized frames, checked
// against a loop-built expected tag sequence and marker/clear counts.
module tb_jpeg_mcu_sched;

    localparam int NS = 4;
    localparam int XW = 13;
    localparam int RW = 16;
    localparam int TW = 7 + 2 * XW;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [1:0]        mode;
    logic [XW-1:0]     mcu_w, mcu_h;
    logic [RW-1:0]     restart_interval;
    logic              dec_req;
    logic [1:0]        dec_comp;
    logic              dec_done;
    logic              dc_pred_clr, rst_expect, rst_seen;
    logic [2:0]        rst_idx;
    logic              err_rst;
    logic [NS-1:0]     stg_start, stg_done;
    logic [NS*TW-1:0]  stg_tag;
    logic              out_valid;
    logic [TW-1:0]     out_tag;
    logic              out_ready, out_empty, busy, frame_done;

    always #5 clk = ~clk;

    jpeg_mcu_sched #(.NUM_STAGES(NS), .XY_W(XW), .RI_W(RW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .mode             (mode),
        .mcu_w            (mcu_w),
        .mcu_h            (mcu_h),
        .restart_interval (restart_interval),
        .dec_req          (dec_req),
        .dec_comp         (dec_comp),
        .dec_done         (dec_done),
        .dc_pred_clr      (dc_pred_clr),
        .rst_expect       (rst_expect),
        .rst_seen         (rst_seen),
        .rst_idx          (rst_idx),
        .err_rst          (err_rst),
        .stg_start        (stg_start),
        .stg_done         (stg_done),
        .stg_tag          (stg_tag),
        .out_valid        (out_valid),
        .out_tag          (out_tag),
        .out_ready        (out_ready),
        .out_empty        (out_empty),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [TW-1:0] exp_q[$];
    logic [1:0]    iss_q[$];
    int            mk_q[$];

    bit resp_on    = 1'b0;
    int done_mode  = 0;
    int ready_mode = 1;
    int exp_mk, n_clr, n_rstexp, n_fd, n_load;
    bit exp_err;
    logic prev_rx = 1'b0;

    // Block order per mode as a plain table: component of block b in mode m.
    int n_blk [4]    = '{1, 3, 4, 6};
    int order [4][6] = '{'{0, 0, 0, 0, 0, 0},
                         '{0, 1, 2, 0, 0, 0},
                         '{0, 0, 1, 2, 0, 0},
                         '{0, 0, 0, 0, 1, 2}};

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Responders: decoder, back-end stages, sink and marker parser.
    initial begin
        dec_done  = 1'b0;
        stg_done  = '0;
        out_ready = 1'b0;
        rst_seen  = 1'b0;
        rst_idx   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_on) begin
                dec_done  = dec_req && ($urandom_range(0, 2) != 0);
                stg_done  = (done_mode == 0) ? {NS{1'b1}} : NS'($urandom);
                out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
                if (rst_expect && !rst_seen && $urandom_range(0, 1) == 1) begin
                    rst_seen = 1'b1;
                    rst_idx  = (mk_q.size() != 0) ? 3'(mk_q.pop_front()) : 3'd0;
                end else begin
                    rst_seen = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every accepted tag and every issued block against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !abort) begin
                check("tag_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("out_tag", 64'(out_tag), 64'(exp_q.pop_front()));
            end
            if (dec_req && dec_done && !abort) begin
                check("issue_expected", 64'(iss_q.size() != 0), 64'd1);
                if (iss_q.size() != 0)
                    check("dec_comp", 64'(dec_comp), 64'(iss_q.pop_front()));
            end
            if (dc_pred_clr) n_clr++;
            if (rst_expect && !prev_rx) n_rstexp++;
            prev_rx = rst_expect;
            if (frame_done) n_fd++;
            if (stg_start[0]) n_load++;
        end
    end

    task automatic start_frame(input int m, input int w, input int h, input int ri, input int bad_mk);
        logic [TW-1:0] t;
        int idx;
        exp_q.delete();
        iss_q.delete();
        mk_q.delete();
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                for (int b = 0; b < n_blk[m]; b++) begin
                    t = '0;
                    t[TW-1]           = (b == n_blk[m] - 1);
                    t[TW-2 -: 4]      = 4'(b);
                    t[TW-6 -: 2]      = 2'(order[m][b]);
                    t[2*XW-1 -: XW]   = XW'(xx);
                    t[XW-1:0]         = XW'(yy);
                    exp_q.push_back(t);
                    iss_q.push_back(2'(order[m][b]));
                end
        exp_mk = (ri == 0) ? 0 : (w * h - 1) / ri;
        for (int i = 0; i < exp_mk; i++) begin
            idx = i % 8;
            if (i == bad_mk) idx = (idx + 2) % 8;
            mk_q.push_back(idx);
        end
        exp_err  = (bad_mk >= 0) && (bad_mk < exp_mk);
        n_clr    = 0;
        n_rstexp = 0;
        n_fd     = 0;
        n_load   = 0;
        @(posedge clk);
        #1;
        mode             = 2'(m);
        mcu_w            = XW'(w);
        mcu_h            = XW'(h);
        restart_interval = RW'(ri);
        start            = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        int cyc;
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_frame_done"}, 64'(frame_done), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({name, "_frame_done_pulse"}, 64'(frame_done), 64'd0);
        check({name, "_tags_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_issues_left"}, 64'(iss_q.size()), 64'd0);
        check({name, "_n_frame_done"}, 64'(n_fd), 64'd1);
        check({name, "_n_rst_expect"}, 64'(n_rstexp), 64'(exp_mk));
        check({name, "_n_dc_clr"}, 64'(n_clr), 64'(1 + exp_mk));
        check({name, "_err_rst"}, 64'(err_rst), 64'(exp_err));
    endtask

    initial begin
        int cyc;
        rst              = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        mode             = '0;
        mcu_w            = XW'(1);
        mcu_h            = XW'(1);
        restart_interval = '0;
        out_empty        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 64'({busy, dec_req, dec_comp, dc_pred_clr, rst_expect, err_rst,
                                 stg_start, out_valid, frame_done}), 64'd0);
        check("reset_stg_tag", 64'(|stg_tag), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);

        // Inputs to idle slots and decoder must be ignored.
        @(posedge clk);
        #1;
        dec_done = 1'b1;
        stg_done = {NS{1'b1}};
        @(posedge clk);
        #1;
        dec_done = 1'b0;
        stg_done = '0;
        @(negedge clk);
        check("idle_ignore", 64'({busy, dec_req, stg_start, out_valid}), 64'd0);
        resp_on = 1'b1;

        // 4:2:0, 2x1 MCUs; DRAIN must wait for out_empty.
        done_mode  = 0;
        ready_mode = 1;
        out_empty  = 1'b0;
        start_frame(3, 2, 1, 0, -1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        check("drain_hold_busy", 64'(busy), 64'd1);
        check("drain_hold_fd", 64'(n_fd), 64'd0);
        out_empty = 1'b1;
        finish_frame("m3_2x1");

        // 4:4:4, 3x2, RI=2 with good markers, then a bad second marker.
        start_frame(1, 3, 2, 2, -1);
        finish_frame("m1_ri2");
        start_frame(1, 3, 2, 2, 1);
        finish_frame("m1_ri2_bad");

        // Smallest frame; RI=1 must not wait for a marker after the only MCU.
        start_frame(0, 1, 1, 1, -1);
        finish_frame("m0_1x1");

        // Gray with a stalled sink: pipeline fills, HAND holds, then resumes.
        ready_mode = 0;
        start_frame(0, 3, 2, 0, -1);
        repeat (60) @(negedge clk);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_dec_req", 64'(dec_req), 64'd0);
        check("stall_loads", 64'(n_load), 64'd4);
        check("stall_head_tag", 64'(out_tag), 64'(exp_q[0]));
        ready_mode = 1;
        finish_frame("m0_stall");

        // Abort with the pipeline partly full, then a clean restart.
        ready_mode = 0;
        start_frame(2, 2, 2, 0, -1);
        cyc = 0;
        while (n_load < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_setup_loads", 64'(n_load >= 3), 64'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_stg_tag", 64'(|stg_tag), 64'd0);
        check("abort_dec_req", 64'(dec_req), 64'd0);
        ready_mode = 1;
        start_frame(2, 2, 2, 0, -1);
        finish_frame("m2_after_abort");

        // Randomized frames with random stage and sink timing.
        done_mode  = 1;
        ready_mode = 2;
        for (int it = 0; it < 6; it++) begin
            start_frame($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                        $urandom_range(0, 3), int'($urandom_range(0, 2)) - 1);
            finish_frame($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_mcu_sched.md
Name: jpeg_mcu_sched

Overview:
- Parametrised MCU scheduler and back-end tag pipeline for the baseline JPEG decoder.
- Issues 8x8 block decode requests to the entropy decoder in MCU order for four chroma modes.
- Handles restart intervals (RSTn markers) and DC-predictor clears.
- Carries each block's position tag through NUM_STAGES back-end stages (dequant, IDCT passes, colour convert) with per-stage start/done handshakes. Sits between the marker parser and the pixel datapath.

Parameters:
NUM_STAGES, 4, number of back-end slots (>=2)
XY_W, 13, width of MCU x/y counters and of mcu_w/mcu_h
RI_W, 16, width of restart interval

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin frame; sampled only in IDLE
abort  in  1  synchronous flush to IDLE
mode  in  2  0 gray(1 blk), 1 4:4:4(3), 2 4:2:2(4), 3 4:2:0(6)
mcu_w  in  XY_W  MCUs per row (>=1)
mcu_h  in  XY_W  MCU rows (>=1)
restart_interval  in  RI_W  MCUs per interval, 0 = disabled
dec_req  out  1  block decode request
dec_comp  out  2  component of requested block (0 Y, 1 Cb, 2 Cr)
dec_done  in  1  pulse: entropy decode of current block finished
dc_pred_clr  out  1  one-cycle pulse: clear all DC predictors
rst_expect  out  1  waiting for RSTn marker
rst_seen  in  1  pulse: RSTn marker consumed
rst_idx  in  3  n of observed RSTn
err_rst  out  1  sticky: RSTn index mismatch
stg_start  out  NUM_STAGES  per-slot one-cycle start pulse
stg_done  in  NUM_STAGES  per-slot done pulse
stg_tag  out  NUM_STAGES*TAG_W  per-slot tag, slot 0 in LSBs
out_valid  out  1  last slot done, tag on out_tag
out_tag  out  TAG_W  {last_in_mcu, blk_idx[3:0], comp[1:0], x[XY_W-1:0], y[XY_W-1:0]}
out_ready  in  1  sink accepts out_tag
out_empty  in  1  downstream pixel buffer drained
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst or abort): state IDLE, all slots invalid, counters 0, expected RSTn index 0. All outputs 0, except err_rst, which is cleared by rst and start only.
- On start in IDLE:
  - latch mode, mcu_w, mcu_h, restart_interval;
  - pulse dc_pred_clr;
  - go ISSUE the next cycle.
- Block order per MCU:
  - mode 0: Y
  - mode 1: Y Cb Cr
  - mode 2: Y Y Cb Cr
  - mode 3: Y Y Y Y Cb Cr
  - blk_idx counts 0..bpm-1, where bpm = blocks per MCU.
- ISSUE: dec_req=1, dec_comp valid. On dec_done go HAND.
  - dec_done outside ISSUE is ignored.
- HAND: when slot0 is invalid, load the tag into slot0 and go NEXT. Otherwise hold.
- NEXT (one cycle):
  - If blk_idx < bpm-1: blk_idx++, go ISSUE.
  - Otherwise blk_idx=0 and the MCU ends:
    - x wraps at mcu_w-1 and y increments; the rst_cnt counter increments.
    - Last MCU (x==mcu_w-1 and y==mcu_h-1): go DRAIN.
    - Else if restart_interval!=0 and rst_cnt==restart_interval: rst_cnt=0, go RSTW.
    - Else go ISSUE.
- RSTW: rst_expect=1. On rst_seen:
  - if rst_idx != expected, set err_rst;
  - expected = expected+1 mod 8;
  - pulse dc_pred_clr; go ISSUE.
  - No RSTW is entered after the last MCU.
- DRAIN: when all slots are invalid and out_empty=1, pulse frame_done for one cycle and go IDLE.
- Slot k:
  - Holds {valid, done, tag}.
  - stg_start[k] is asserted in the first cycle valid is 1.
  - stg_done[k] sets done while valid & !done, including that first cycle. It is ignored when the slot is invalid.
  - Slot k>=1 loads from k-1 when slot k-1 is valid & done and slot k is invalid. Slot k-1 then clears.
  - No same-cycle refill: a slot freed at edge t may load at edge t+1 at the earliest.
- Last slot: out_valid = valid & done. The out_valid && out_ready handshake clears it.
- Simultaneous events:
  - A load into slot0 and a move out of slot0 cannot coincide, because of the invalid-only load rule.
  - abort has priority over all other events.
  - start is ignored outside IDLE.
- x, y and rst_cnt are unsigned and wrap only as stated.
- mcu_w=1 and mcu_h=1 are legal.
- last_in_mcu = (blk_idx == bpm-1).

Decomposition:
- Package jpeg_sched_pkg:
  - state encodings (IDLE, ISSUE, HAND, NEXT, RSTW, DRAIN);
  - mode constants;
  - per-mode bpm and component lookup function;
  - TAG_W localparam.
- Sub-module jpeg_tag_slot: one slot's valid/done/tag register with start pulse. Instantiated NUM_STAGES times via generate.

Test Plan:
- Mode 3, 2x1 MCUs, RI=0, stages done next cycle, out_ready=1 → 12 tags in order, comps Y,Y,Y,Y,Cb,Cr twice, x=0 then 1, last_in_mcu on blocks 5 and 11. frame_done one cycle after the last drain with out_empty=1.
- Mode 1, 3x2 MCUs, RI=2, rst_seen with idx 0 then 1 → rst_expect is asserted twice (after MCUs 2 and 4, never after 6). dc_pred_clr fires 3 times, err_rst=0.
- Same setup, second marker reported with idx 3 → err_rst=1 stays set to frame end; decoding completes.
- Mode 0, NUM_STAGES=4, out_ready held 0 → pipeline fills 4 tags, HAND holds, dec_req stays 0. Releasing out_ready resumes with no lost or duplicate tag.
- abort while 3 slots are valid in mode 2 → next cycle: busy=0, all stg_tag valid bits cleared, no out_valid. A following start restarts from x=0, y=0, blk 0.
- stg_done pulse to an empty slot, and dec_done in IDLE → no state change.
